mem_port_arbiter: RTL

//  Shares the single unified instruction/data memory between the multicycle CPU

---
 rtl/mem_port_arbiter_if.sv | 18 +
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester port of the unified-memory arbiter: request/handshake plus a
// registered read response. One instance per requester (CPU, debug unit).
interface mem_port_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 32
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   // requester side drives the access, arbiter side answers it
   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the unified instruction/data memory between the CPU (fetch, LW/SW)
// and the debug unit. One access in flight; IDLE -> ISSUE -> WAIT -> RESP.
// Requests are sampled only in IDLE/RESP, so a request still high during its
// grant cycle is not granted a second time.
module mem_port_arbiter #(
   parameter int AW         = 8,
   parameter int DW         = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave cpu,
   mem_port_arbiter_if.slave dbg,
   output logic              mem_en,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata,
   output logic              busy
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int LW = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

   state_t        state, state_nxt;
   owner_t        owner;
   logic          op_we;
   logic [LW-1:0] lat_cnt;
   logic [SW-1:0] starve;
   logic [DW-1:0] cpu_rdata, dbg_rdata;
   logic          arb, any_req, pick_dbg, last_wait;

   // arbitration decision and next-state logic
   always_comb begin
      arb       = (state == IDLE) || (state == RESP);
      any_req   = cpu.req || dbg.req;
      // debug wins when alone, or when the CPU has starved it long enough
      pick_dbg  = dbg.req && (!cpu.req || (starve == SW'(STARVE_MAX)));
      last_wait = (state == WAIT) && (lat_cnt == LW'(1));
      state_nxt = state;
      case (state)
         IDLE, RESP: state_nxt = any_req ? ISSUE : IDLE;
         ISSUE:      state_nxt = WAIT;
         WAIT:       if (last_wait) state_nxt = RESP;
         default:    state_nxt = IDLE;
      endcase
   end

   // state register, winner latch, latency down-counter, starvation counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= OWN_CPU;
         op_we     <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         lat_cnt   <= '0;
         starve    <= '0;
      end else begin
         state <= state_nxt;
         if (arb && any_req) begin
            owner     <= pick_dbg ? OWN_DBG : OWN_CPU;
            op_we     <= pick_dbg ? dbg.we    : cpu.we;
            mem_addr  <= pick_dbg ? dbg.addr  : cpu.addr;
            mem_wdata <= pick_dbg ? dbg.wdata : cpu.wdata;
         end
         if (state == ISSUE)
            lat_cnt <= LW'(MEM_LAT);
         else if (state == WAIT)
            lat_cnt <= lat_cnt - LW'(1);
         // counts CPU wins over a waiting debug request; any other outcome clears it
         if (arb) begin
            if (!dbg.req || pick_dbg)
               starve <= '0;
            else if (starve != SW'(STARVE_MAX))
               starve <= starve + SW'(1);
         end
      end
   end

   // read data capture at the end of the last wait cycle; writes leave it alone
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_rdata <= '0;
         dbg_rdata <= '0;
      end else if (last_wait && !op_we) begin
         if (owner == OWN_DBG)
            dbg_rdata <= mem_rdata;
         else
            cpu_rdata <= mem_rdata;
      end
   end

   // strobes decoded from the registered state
   always_comb begin
      mem_en = (state == ISSUE);
      mem_we = mem_en && op_we;
      busy   = (state != IDLE);
   end

   assign cpu.gnt    = mem_en && (owner == OWN_CPU);
   assign dbg.gnt    = mem_en && (owner == OWN_DBG);
   assign cpu.rvalid = (state == RESP) && (owner == OWN_CPU);
   assign dbg.rvalid = (state == RESP) && (owner == OWN_DBG);
   assign cpu.rdata  = cpu_rdata;
   assign dbg.rdata  = dbg_rdata;
endmodule
